color_merge_pipe: RTL

- Synthesizable, parametrised successor to the coloring-simulator merge node.
- Holds the latest color mask for each of NIN input channels and ORs them into one merged mask.
- Merged mask is delayed through a DEPTH-stage register pipeline, so flop-depth is modelled in hardware.
- Flags cross-clock-domain mixing, records the first offending channel, and counts merged-mask changes for the coloring flow.

---
 rtl/color_pkg.sv | 35 +++
 rtl/color_pipe_stage.sv | 27 ++
 rtl/color_merge_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// Shared defaults, the cross-domain status record and the mask helper functions
// used by the color merge pipeline.
package color_pkg;

  localparam int DEF_BW = 64;
  localparam logic [63:0] DEF_CLKMASK = 64'h0000_0000_0000_FFFF;
  localparam int CHW = 5;

  // Helpers take the widest supported mask / channel vector; callers zero-extend.
  localparam int MAX_BW = 256;
  localparam int MAX_CH = 32;

  typedef logic [MAX_BW-1:0] wide_mask_t;
  typedef logic [MAX_CH-1:0] ch_vec_t;

  typedef struct packed {
    logic           flag;
    logic [CHW-1:0] ch;
  } xdom_t;

  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  function automatic logic gt1(input wide_mask_t mask);
    return |(mask & (mask - wide_mask_t'(1)));
  endfunction

  function automatic logic [CHW-1:0] first_one(input ch_vec_t vec);
    logic [CHW-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CHW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/color_pipe_stage.sv
// One BW-wide delay stage of the merged-mask output pipeline.
module color_pipe_stage
  import color_pkg::*;
#(
  parameter int BW = DEF_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] d,
  output logic [BW-1:0] q
);

  logic [BW-1:0] data_d;
  logic [BW-1:0] data_q;

  always_comb begin
    data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/color_merge_pipe.sv
// Merge node: holds the latest mask per channel, ORs them, delays the result by
// DEPTH stages, flags clock-domain mixing and counts merged-mask changes.
module color_merge_pipe
  import color_pkg::*;
#(
  parameter int            BW      = DEF_BW,
  parameter int            NIN     = 10,
  parameter int            DEPTH   = 1,
  parameter logic [BW-1:0] CLKMASK = BW'(DEF_CLKMASK),
  parameter int            CW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    in_vld,
  input  logic [NIN*BW-1:0] in_color,
  input  logic              clear,
  output logic [BW-1:0]     out_color,
  output logic              out_vld,
  output logic              xdom,
  output logic [CHW-1:0]    xdom_ch,
  output logic [CW-1:0]     chg_cnt
);

  logic [BW-1:0]  hold_q [NIN];
  logic [BW-1:0]  hold_d [NIN];
  logic [BW-1:0]  merged;
  logic [BW-1:0]  merged_d;
  logic [NIN-1:0] contrib;
  xdom_t          xdom_q, xdom_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  prev_q, prev_d;
  logic [BW-1:0]  stage [DEPTH+1];

  always_comb begin
    merged = '0;
    for (int i = 0; i < NIN; i++) begin
      merged = merged | hold_q[i];
    end
  end

  // Next hold contents, the merged value they produce, and which updating
  // channels bring in a clock-domain bit that is not yet present.
  always_comb begin
    merged_d = '0;
    contrib  = '0;
    for (int i = 0; i < NIN; i++) begin
      hold_d[i] = hold_q[i];
      if (clear)          hold_d[i] = '0;
      else if (in_vld[i]) hold_d[i] = in_color[i*BW +: BW];
      merged_d   = merged_d | hold_d[i];
      contrib[i] = in_vld[i] & (|(in_color[i*BW +: BW] & CLKMASK & ~merged));
    end
  end

  always_comb begin
    xdom_d = xdom_q;
    if (clear) begin
      xdom_d = '0;
    end else if (!xdom_q.flag && gt1(wide_mask_t'(merged_d & CLKMASK))) begin
      xdom_d.flag = 1'b1;
      xdom_d.ch   = first_one(ch_vec_t'(contrib));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((merged_d != merged) && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    prev_d = out_color;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NIN; i++) hold_q[i] <= '0;
      xdom_q <= '0;
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) hold_q[i] <= hold_d[i];
      xdom_q <= xdom_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  // With DEPTH=0 no stages are built and out_color is the merged value itself.
  assign stage[0] = merged;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    color_pipe_stage #(
      .BW(BW)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .d  (stage[gi]),
      .q  (stage[gi+1])
    );
  end

  assign out_color = stage[DEPTH];
  assign out_vld   = (out_color != prev_q);
  assign xdom      = xdom_q.flag;
  assign xdom_ch   = xdom_q.ch;
  assign chg_cnt   = cnt_q;

endmodule
